alu_dmem_immgen: RTL and testbench

//  Execute/memory slice of the single-cycle RV32 datapath: immediate generator, ALU and word-addressed data memory.
//  The three paths are independent.
//  - Imm-gen and ALU are combinational.
//  - Data memory writes synchronously and reads through a registered port.

---
 rtl/alu_dmem_immgen.sv | 125 ++++++++++++
 tb/tb_alu_dmem_immgen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dmem_immgen.sv
// RV32 execute/memory slice: combinational imm-gen and ALU, word memory with 1-cycle registered read.
// No flow control; optional per-byte write masking when DM_BYTE_WRITE_EN is defined.
module alu_dmem_immgen #(
  parameter int    WORD_SIZE = 32,
  parameter int    DM_DEPTH  = 256,
  parameter string DM_FILE   = ""
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [31:0]          i_Instruction,
  output logic [31:0]          o_ExtendedImmediate,
  input  logic [3:0]           i_Operation,
  input  logic [WORD_SIZE-1:0] i_Op1,
  input  logic [WORD_SIZE-1:0] i_Op2,
  output logic [WORD_SIZE-1:0] o_Result,
  output logic                 o_Zero,
  input  logic [31:0]          i_Addr,
  input  logic [WORD_SIZE-1:0] i_Wd,
  input  logic                 i_Wen,
  input  logic                 i_Ren,
`ifdef DM_BYTE_WRITE_EN
  input  logic [3:0]           i_ByteMask,
`endif
  output logic [WORD_SIZE-1:0] o_Rd
);

  localparam int AW = $clog2(DM_DEPTH);

  // Immediate generator
  logic [6:0]  opcode;
  logic [31:0] imm;

  assign opcode = i_Instruction[6:0];

  always_comb begin
    imm = '0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111:
        imm = {{20{i_Instruction[31]}}, i_Instruction[31:20]};
      7'b0100011:
        imm = {{20{i_Instruction[31]}}, i_Instruction[31:25], i_Instruction[11:7]};
      7'b1100011:
        imm = {{19{i_Instruction[31]}}, i_Instruction[31], i_Instruction[7],
               i_Instruction[30:25], i_Instruction[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm = {i_Instruction[31:12], 12'b0};
      7'b1101111:
        imm = {{11{i_Instruction[31]}}, i_Instruction[31], i_Instruction[19:12],
               i_Instruction[20], i_Instruction[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign o_ExtendedImmediate = imm;

  // ALU
  logic [4:0]           shamt;
  logic [WORD_SIZE-1:0] result;

  assign shamt = i_Op2[4:0];

  always_comb begin
    result = '0;
    case (i_Operation)
      4'b0000: result = i_Op1 & i_Op2;
      4'b0001: result = i_Op1 | i_Op2;
      4'b0010: result = i_Op1 + i_Op2;
      4'b0110: result = i_Op1 - i_Op2;
      4'b0011: result = i_Op1 ^ i_Op2;
      4'b1100: result = ~(i_Op1 | i_Op2);
      4'b0100: result = i_Op1 << shamt;
      4'b0101: result = i_Op1 >> shamt;
      4'b1000: result = $signed(i_Op1) >>> shamt;
      4'b0111: result = {{(WORD_SIZE-1){1'b0}}, $signed(i_Op1) < $signed(i_Op2)};
      4'b1001: result = {{(WORD_SIZE-1){1'b0}}, i_Op1 < i_Op2};
      default: result = '0;
    endcase
  end

  assign o_Result = result;
  assign o_Zero   = (result == '0);

  // Data memory
  logic [WORD_SIZE-1:0] mem [DM_DEPTH];
  logic [AW-1:0]        idx;
  logic [3:0]           byte_en;
  logic                 unused_addr;
  logic [WORD_SIZE-1:0] rd_d, rd_q;

  assign idx         = i_Addr[AW-1:0];
  assign unused_addr = ^i_Addr[31:AW];

`ifdef DM_BYTE_WRITE_EN
  assign byte_en = i_Wen ? i_ByteMask : 4'b0000;
`else
  assign byte_en = {4{i_Wen}};
`endif

  initial begin
    for (int k = 0; k < DM_DEPTH; k++) mem[k] = '0;
  end

  // Contents survive reset; only the write strobe is gated by it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= i_Wd[8*b +: 8];
      end
    end
  end

  // Sampling mem before the write lands gives read-before-write on collisions.
  always_comb begin
    rd_d = rd_q;
    if (i_Ren) rd_d = mem[idx];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  assign o_Rd = rd_q;

endmodule

// File: tb/tb_alu_dmem_immgen.sv
// Bench for alu_dmem_immgen: vector tables, directed memory/reset sequences, randomized model checks.
module tb_alu_dmem_immgen;

  localparam int DEPTH = 256;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_Instruction, o_ExtendedImmediate;
  logic [3:0]  i_Operation;
  logic [31:0] i_Op1, i_Op2, o_Result;
  logic        o_Zero;
  logic [31:0] i_Addr, i_Wd, o_Rd;
  logic        i_Wen, i_Ren;
`ifdef DM_BYTE_WRITE_EN
  logic [3:0]  i_ByteMask;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_dmem_immgen #(.WORD_SIZE(32), .DM_DEPTH(DEPTH), .DM_FILE("")) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_Instruction(i_Instruction), .o_ExtendedImmediate(o_ExtendedImmediate),
    .i_Operation(i_Operation), .i_Op1(i_Op1), .i_Op2(i_Op2),
    .o_Result(o_Result), .o_Zero(o_Zero),
    .i_Addr(i_Addr), .i_Wd(i_Wd), .i_Wen(i_Wen), .i_Ren(i_Ren),
`ifdef DM_BYTE_WRITE_EN
    .i_ByteMask(i_ByteMask),
`endif
    .o_Rd(o_Rd)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm;
  } imm_vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } alu_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int sx(input int val, input int bits);
    return (val >= (1 << (bits - 1))) ? val - (1 << bits) : val;
  endfunction

  // Reference immediate built from field arithmetic.
  function automatic logic [31:0] imm_ref(input logic [31:0] ins);
    int v;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: v = sx(int'(ins[31:20]), 12);
      7'h23: v = sx(int'(ins[31:25]) * 32 + int'(ins[11:7]), 12);
      7'h63: v = sx(int'(ins[31]) * 4096 + int'(ins[7]) * 2048
                    + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2, 13);
      7'h37, 7'h17: return ins & 32'hFFFF_F000;
      7'h6F: v = sx(int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * (1 << 12)
                    + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2, 21);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return 32'(longint'(a) + longint'(b));
      4'h6: return 32'(longint'(a) - longint'(b));
      4'h3: return a ^ b;
      4'hC: return ~(a | b);
      4'h4: return a << sh;
      4'h5: return a >> sh;
      4'h8: return a[31] ? ~((~a) >> sh) : (a >> sh);
      4'h7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'h9: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  imm_vec_t    imm_tab[9];
  alu_vec_t    alu_tab[14];
  logic [31:0] model[DEPTH];
  logic [31:0] exp_rd;
  logic [6:0]  opc_list[9];

  initial begin
    imm_tab[0] = '{32'hFFF00093, 32'hFFFFFFFF};
    imm_tab[1] = '{32'h00A12423, 32'h00000008};
    imm_tab[2] = '{32'hFE000EE3, 32'hFFFFFFFC};
    imm_tab[3] = '{32'h123450B7, 32'h12345000};
    imm_tab[4] = '{32'hFFFFFFFF, 32'h00000000};
    imm_tab[5] = '{32'h0080006F, 32'h00000008};
    imm_tab[6] = '{32'hFFFFF017, 32'hFFFFF000};
    imm_tab[7] = '{32'h80000067, 32'hFFFFF800};
    imm_tab[8] = '{32'h7FF02003, 32'h000007FF};

    alu_tab[0]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    alu_tab[1]  = '{4'b0110, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0};
    alu_tab[2]  = '{4'b0111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0};
    alu_tab[3]  = '{4'b1001, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1};
    alu_tab[4]  = '{4'b1000, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0};
    alu_tab[5]  = '{4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1};
    alu_tab[6]  = '{4'b0000, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b0};
    alu_tab[7]  = '{4'b0001, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0};
    alu_tab[8]  = '{4'b0011, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0};
    alu_tab[9]  = '{4'b1100, 32'hF0F00000, 32'h0F0F0000, 32'h0000FFFF, 1'b0};
    alu_tab[10] = '{4'b0100, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0};
    alu_tab[11] = '{4'b0101, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0};
    alu_tab[12] = '{4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    alu_tab[13] = '{4'b0110, 32'h00000009, 32'h00000009, 32'h00000000, 1'b1};

    opc_list = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    i_rst = 1'b1;
    i_Instruction = '0; i_Operation = '0; i_Op1 = '0; i_Op2 = '0;
    i_Addr = '0; i_Wd = '0; i_Wen = 1'b0; i_Ren = 1'b0;
`ifdef DM_BYTE_WRITE_EN
    i_ByteMask = 4'hF;
`endif
    #1;
    check("reset_rd", o_Rd, 32'h0);
    tick();
    i_rst = 1'b0;

    foreach (imm_tab[i]) begin
      i_Instruction = imm_tab[i].ins;
      #1;
      check($sformatf("imm_tab[%0d]", i), o_ExtendedImmediate, imm_tab[i].imm);
    end

    foreach (alu_tab[i]) begin
      i_Operation = alu_tab[i].op; i_Op1 = alu_tab[i].a; i_Op2 = alu_tab[i].b;
      #1;
      check($sformatf("alu_tab[%0d].res", i), o_Result, alu_tab[i].res);
      check($sformatf("alu_tab[%0d].zero", i), 32'(o_Zero), 32'(alu_tab[i].zero));
    end

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0] = ($urandom_range(0, 4) == 0) ? 7'($urandom) : opc_list[$urandom_range(0, 8)];
      i_Instruction = ins;
      i_Operation = 4'($urandom);
      i_Op1 = ($urandom_range(0, 3) == 0) ? i_Op2 : $urandom;
      i_Op2 = $urandom;
      #1;
      check($sformatf("rand_imm %h", ins), o_ExtendedImmediate, imm_ref(ins));
      check($sformatf("rand_alu op%h", i_Operation), o_Result, alu_ref(i_Operation, i_Op1, i_Op2));
      check("rand_zero", 32'(o_Zero), 32'(alu_ref(i_Operation, i_Op1, i_Op2) == 0));
    end

    // Basic write, read latency, aliasing and hold.
    @(posedge i_clk); #1;
    i_Wen = 1'b1; i_Addr = 32'd3; i_Wd = 32'hDEADBEEF;
    tick();
    i_Addr = 32'd4; i_Wd = 32'h12345678;
    tick();
    i_Wen = 1'b0; i_Ren = 1'b1; i_Addr = 32'd3;
    #3;
    check("rd_before_edge", o_Rd, 32'h0);
    tick();
    check("rd_addr3", o_Rd, 32'hDEADBEEF);
    i_Addr = 32'd4;
    tick();
    check("rd_addr4", o_Rd, 32'h12345678);
    i_Addr = DEPTH + 3;
    tick();
    check("rd_alias", o_Rd, 32'hDEADBEEF);
    i_Ren = 1'b0; i_Addr = 32'd4;
    tick();
    check("rd_hold", o_Rd, 32'hDEADBEEF);

    // Same-cycle read and write of one index.
    i_Wen = 1'b1; i_Addr = 32'd5; i_Wd = 32'h22222222;
    tick();
    i_Ren = 1'b1; i_Wd = 32'h11111111;
    tick();
    check("collide_old", o_Rd, 32'h22222222);
    i_Wen = 1'b0;
    tick();
    check("collide_new", o_Rd, 32'h11111111);

    // Asynchronous reset mid-cycle, write suppressed, contents kept.
    i_Addr = 32'd3;
    tick();
    check("pre_reset_rd", o_Rd, 32'hDEADBEEF);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_clear", o_Rd, 32'h0);
    i_Wen = 1'b1; i_Wd = 32'h55555555;
    tick();
    check("rd_held_in_reset", o_Rd, 32'h0);
    i_rst = 1'b0; i_Wen = 1'b0;
    tick();
    check("mem_kept_after_reset", o_Rd, 32'hDEADBEEF);

`ifdef DM_BYTE_WRITE_EN
    i_Ren = 1'b0; i_Wen = 1'b1; i_Addr = 32'd7; i_Wd = 32'h0; i_ByteMask = 4'hF;
    tick();
    i_Wd = 32'hAABBCCDD; i_ByteMask = 4'b0101;
    tick();
    i_Wd = 32'hFFFFFFFF; i_ByteMask = 4'b0000;
    tick();
    i_Wen = 1'b0; i_Ren = 1'b1; i_ByteMask = 4'hF;
    tick();
    check("byte_mask", o_Rd, 32'h00BB00DD);
`endif

    // Random traffic against an array model.
    i_Ren = 1'b0; i_Wen = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      i_Addr = a + DEPTH * $urandom_range(0, 7);
      i_Wd = $urandom;
      model[a] = i_Wd;
      tick();
    end
    exp_rd = o_Rd;
    for (int i = 0; i < 1500; i++) begin
      int idx;
      i_Wen  = 1'($urandom);
      i_Ren  = (i == 0) ? 1'b1 : 1'($urandom);
      i_Addr = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      i_Wd   = $urandom;
      idx    = int'(i_Addr % DEPTH);
      if (i_Ren) exp_rd = model[idx];
`ifdef DM_BYTE_WRITE_EN
      i_ByteMask = 4'($urandom);
      if (i_Wen) begin
        for (int b = 0; b < 4; b++)
          if (i_ByteMask[b]) model[idx][8*b +: 8] = i_Wd[8*b +: 8];
      end
`else
      if (i_Wen) model[idx] = i_Wd;
`endif
      tick();
      check($sformatf("rand_mem[%0d]", i), o_Rd, exp_rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
